slope_tracker: RTL
==================

# slope_tracker

Trend and turning-point controller built around the slope datapath. It qualifies a sample stream with a valid strobe, compares each accepted sample against the previously accepted one, and confirms rising or falling trends with hysteresis. It emits single-cycle peak/valley events carrying the extreme value. It sits between a sample source (ADC front end, filter output) and downstream event logic, and replaces free-running slope comparison where samples arrive irregularly.

## Interface
- WIDTH, 16, sample width; unsigned.
- HOLD, 3, consecutive reversal-direction samples needed to confirm a trend change; HOLD ≥ 1.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear to the post-reset state; wins over in_valid.
- in_valid  input  1  datain is accepted on a clk edge where in_valid=1.
- datain  input  WIDTH  sample.
- trend  output  2  00 INIT, 01 RISING, 10 FALLING; 11 never driven.
- peak  output  1  one-cycle pulse: RISING→FALLING confirmed.
- valley  output  1  one-cycle pulse: FALLING→RISING confirmed.
- extreme  output  WIDTH  value reported with the last peak/valley; held until the next event.
- eq, lt, gt  output  1 each  registered result of the last comparison (prev vs datain; lt means prev < datain).

## Operation
- Internal state: prev (WIDTH), primed (1), run counter (saturates at HOLD, width $clog2(HOLD+1)), ext (WIDTH), FSM {INIT, RISING, FALLING}.
- First accepted sample after reset/flush: prev ← datain, primed ← 1. No comparison; eq/lt/gt unchanged.
- Every later accepted sample: dir = up (datain > prev), down (datain < prev), flat (equal). Then prev ← datain and {eq,lt,gt} ← comparison.
- Flat samples never change run, state or ext.
- INIT: a non-flat sample with the same dir as the previous non-flat sample increments run. An opposite dir sets run=1. When run reaches HOLD, go to RISING (up) or FALLING (down), set ext ← datain and run ← 0. No event is emitted.
- RISING: ext ← max(ext, datain) on every accepted sample.
  - up sample: run ← 0.
  - down sample: run ← run+1. On reaching HOLD: go to FALLING, pulse peak, extreme ← ext (the max, excluding the current sample), ext ← datain, run ← 0.
- FALLING: mirror of RISING. ext tracks the min, up samples count, confirmation pulses valley.
- in_valid=0: no state change. peak/valley are 0 that cycle.
- flush=1: primed, run, trend, peak, valley, eq, lt and gt cleared, state INIT. extreme is retained. Any concurrent sample is discarded.
- rst: all registers, including extreme and prev, go to 0 immediately. Every output reads 0 while rst is high.

## Timing
- All outputs are registered. peak/valley/extreme/trend update on the same clk edge that accepts the confirming sample, i.e. visible in the following cycle. Latency is 1 cycle.
- peak/valley pulse for exactly one cycle and are never both high.
- Back-to-back in_valid at full rate is supported; no backpressure.
- HOLD=1: each single reversal sample confirms immediately.
- Reset released mid-stream: the first accepted sample only re-primes prev.

## Test plan
- Reset: assert rst mid-run with in_valid high → trend=00, peak=valley=0, extreme=0, eq=lt=gt=0 within the same cycle. Stay cleared until the first two samples after release.
- Rising confirm (HOLD=3): accept 10,20,30,40 → trend=01 after the 40 edge. No peak/valley. lt=1.
- Peak: continue 50,45,40,35 → peak=1 for one cycle after 35 with extreme=50, trend=10.
- Hysteresis and flats: continue 36,35,35,37,38 → no valley (run restarted by 35; the flat 35 is ignored). Then 39 → valley pulse with extreme=35, trend=01.
- Gaps: repeat the peak sequence with in_valid low for 1–5 random cycles between samples → identical events and values, with only the cycle position shifted.
- Flush: in RISING with run=2, assert flush together with in_valid (datain=5) → trend=00, no event, extreme holds its prior value. The next accepted sample only primes prev.

Source files
------------

// File: rtl/slope_tracker.sv
// Trend and turning-point tracker for a qualified sample stream.
// Confirms rising/falling trends with hysteresis and reports peaks/valleys.
module slope_tracker #(
  parameter int WIDTH = 16,
  parameter int HOLD  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] datain,
  output logic [1:0]       trend,
  output logic             peak,
  output logic             valley,
  output logic [WIDTH-1:0] extreme,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int RW = $clog2(HOLD + 1);
  localparam logic [RW-1:0] HOLD_R = RW'(HOLD);

  typedef enum logic [1:0] {
    S_INIT = 2'b00,
    S_RISE = 2'b01,
    S_FALL = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    D_NONE = 2'b00,
    D_UP   = 2'b01,
    D_DN   = 2'b10
  } dir_e;

  state_e           state_q, state_d;
  dir_e             last_q, last_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] ext_q, ext_d;
  logic [WIDTH-1:0] extreme_q, extreme_d;
  logic [RW-1:0]    run_q, run_d;
  logic             primed_q, primed_d;
  logic             peak_q, peak_d;
  logic             valley_q, valley_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  logic             is_up;
  logic             is_dn;
  dir_e             dir_now;
  logic [RW-1:0]    run_inc;
  logic [RW-1:0]    run_n;

  assign is_up   = datain > prev_q;
  assign is_dn   = datain < prev_q;
  assign dir_now = is_up ? D_UP : (is_dn ? D_DN : D_NONE);
  assign run_inc = (run_q == HOLD_R) ? run_q : run_q + RW'(1);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    prev_d    = prev_q;
    ext_d     = ext_q;
    extreme_d = extreme_q;
    run_d     = run_q;
    primed_d  = primed_q;
    peak_d    = 1'b0;
    valley_d  = 1'b0;
    eq_d      = eq_q;
    lt_d      = lt_q;
    gt_d      = gt_q;
    run_n     = run_inc;

    if (flush) begin
      state_d  = S_INIT;
      last_d   = D_NONE;
      run_d    = '0;
      primed_d = 1'b0;
      eq_d     = 1'b0;
      lt_d     = 1'b0;
      gt_d     = 1'b0;
    end else if (in_valid && !primed_q) begin
      prev_d   = datain;
      primed_d = 1'b1;
    end else if (in_valid) begin
      prev_d = datain;
      eq_d   = !is_up && !is_dn;
      lt_d   = is_up;
      gt_d   = is_dn;
      unique case (state_q)
        S_INIT: begin
          if (is_up || is_dn) begin
            // a direction change restarts the streak at one
            run_n  = (last_q == dir_now) ? run_inc : RW'(1);
            last_d = dir_now;
            if (run_n == HOLD_R) begin
              state_d = is_up ? S_RISE : S_FALL;
              ext_d   = datain;
              run_d   = '0;
            end else begin
              run_d = run_n;
            end
          end
        end
        S_RISE: begin
          if (is_up) begin
            run_d = '0;
            if (datain > ext_q) ext_d = datain;
          end else if (is_dn) begin
            if (run_inc == HOLD_R) begin
              state_d   = S_FALL;
              peak_d    = 1'b1;
              extreme_d = ext_q;
              ext_d     = datain;
              run_d     = '0;
            end else begin
              run_d = run_inc;
            end
          end
        end
        S_FALL: begin
          if (is_dn) begin
            run_d = '0;
            if (datain < ext_q) ext_d = datain;
          end else if (is_up) begin
            if (run_inc == HOLD_R) begin
              state_d   = S_RISE;
              valley_d  = 1'b1;
              extreme_d = ext_q;
              ext_d     = datain;
              run_d     = '0;
            end else begin
              run_d = run_inc;
            end
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      last_q    <= D_NONE;
      prev_q    <= '0;
      ext_q     <= '0;
      extreme_q <= '0;
      run_q     <= '0;
      primed_q  <= 1'b0;
      peak_q    <= 1'b0;
      valley_q  <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      prev_q    <= prev_d;
      ext_q     <= ext_d;
      extreme_q <= extreme_d;
      run_q     <= run_d;
      primed_q  <= primed_d;
      peak_q    <= peak_d;
      valley_q  <= valley_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      gt_q      <= gt_d;
    end
  end

  assign trend   = state_q;
  assign peak    = peak_q;
  assign valley  = valley_q;
  assign extreme = extreme_q;
  assign eq      = eq_q;
  assign lt      = lt_q;
  assign gt      = gt_q;

endmodule
